calc_sched: RTL and testbench
=============================

# calc_sched

Sequencing controller for the `y = {sign, a·b·cos(c)/(a+d)}` datapath. It bit-serially loads the coefficient `d` through the datapath's `e` input after each datapath reset, then admits operand triples with a valid/ready handshake. It tracks in-flight results with a tag pipeline matched to datapath latency and buffers results in a credit-protected FIFO, so no result is dropped under output backpressure. It sits between the system bus side and the datapath instance and is the only agent driving the datapath's `rst`, `e`, `a`, `b` and `c`.

## Interface
- `LAT`, 6: cycles from an operand-issue edge to the edge at which `dp_y` holds that result.
- `FIFO_DEPTH`, 8: result FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the caller tag carried with each operation.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1, `cfg_ready` out 1, `cfg_d` in 12: coefficient load/reload request.
- `in_valid` in 1, `in_ready` out 1: operand handshake.
- `in_a`, `in_b`, `in_c` in 12 each; `in_tag` in TAG_W.
- `out_valid` out 1, `out_ready` in 1, `out_y` out 13, `out_tag` out TAG_W.
- `dp_rst` out 1: datapath synchronous active-high reset.
- `dp_e` out 1: serial `d` bit.
- `dp_a`, `dp_b`, `dp_c` out 12 each; `dp_y` in 13.
- `loaded` out 1: `d` is valid and the block is in RUN.
- `busy` out 1: state ≠ IDLE, or in-flight count > 0, or FIFO non-empty.

## Operation
- **States:** IDLE, LOAD, RUN, DRAIN.
- **IDLE:** `dp_rst`=1, `cfg_ready`=1. When `cfg_valid` is sampled high, latch `cfg_d` into a shift register, clear the bit counter and go to LOAD.
- **LOAD:** `dp_rst`=0. Exactly 12 cycles; in load cycle i (i=0..11), `dp_e` = `cfg_d[i]` (LSB first). After the 12th cycle, go to RUN.
- **RUN:** `in_ready` = `!cfg_valid && (inflight + fifo_count) < FIFO_DEPTH`. A FIFO pop in the same cycle is not credited. On handshake, register `in_a`/`in_b`/`in_c` onto `dp_a`/`dp_b`/`dp_c` and push `{1, in_tag}` into a LAT-deep valid/tag shift register. When no operation is issued, `dp_a`/`dp_b`/`dp_c` hold their values and a 0 valid is shifted in.
- **Capture:** When the shift-register tail is valid, write `{dp_y, tag}` into the FIFO. The credit rule guarantees the FIFO is never full at that point.
- **Reload:** `cfg_valid` high in RUN forces `in_ready`=0 and moves to DRAIN. DRAIN stays until inflight = 0, then goes to IDLE. IDLE lasts at least one cycle (datapath reset), then accepts `cfg_d` as above. Buffered FIFO results survive a reload and are still delivered.
- **Output:** `out_valid` = FIFO non-empty; `out_y`/`out_tag` come from the FIFO head; pop on `out_valid && out_ready`.
- **Width rules:** `dp_y` is passed through unmodified. The inflight counter is `$clog2(LAT+1)` bits; the FIFO count is `$clog2(FIFO_DEPTH+1)` bits.

## Timing
- **Reset (async assert):** state=IDLE, `dp_rst`=1, `dp_e`=0, `dp_a`/`dp_b`/`dp_c`=0, `in_ready`=0, `cfg_ready`=1, `out_valid`=0, `out_y`=0, `out_tag`=0, `loaded`=0, `busy`=0. The FIFO and tag pipe are cleared; all in-flight results are lost.
- **Load latency:** `cfg` accept edge → 12 LOAD cycles → `loaded`=1 and `in_ready` may rise on the 13th edge after accept.
- **Result latency:** issue edge t → FIFO write at edge t+LAT → `out_valid` at edge t+LAT+1 (minimum issue-to-output latency LAT+1). Throughput is one operation per cycle while credit is available.
- **Simultaneous push and pop:** FIFO count unchanged. Push and pop on an empty FIFO are not allowed; data appears the cycle after the write.
- **`cfg_valid` and `in_valid` together in RUN:** `cfg` wins; the operand is not accepted.
- **FIFO full with `out_ready`=0:** `in_ready` stays 0 until `inflight + fifo_count < FIFO_DEPTH`.

## Structure
- **Package `calc_pkg`:** state enum `calc_state_t`, `D_W`=12, `Y_W`=13, `LOAD_CYCLES`=12, `LAT_DEFAULT`=6.
- **Sub-module `calc_res_fifo`:** synchronous FIFO, parameterised width/depth, registered head, count output. All other logic lives in `calc_sched`.

## Test plan
- Reset, then `cfg_d`=12'hA5C → `dp_e` sequence 0,0,1,1,1,0,1,0,0,1,0,1 over 12 cycles with `dp_rst`=0; `loaded`=1 on the 13th edge.
- Ten back-to-back ops (tags 0..9) with `out_ready`=1 → each `out_y` equals the datapath model result, tags in order, first `out_valid` 7 edges after first issue.
- `out_ready`=0 while streaming → exactly 8 ops accepted, then `in_ready`=0. Releasing `out_ready` drains tags 0..7 and re-admits without loss.
- `cfg_valid` mid-stream with 3 ops in flight → `in_ready` drops immediately; the 3 results reach the FIFO; IDLE asserts `dp_rst` for ≥1 cycle; the new `d` loads; pre-reload results are delivered with their original tags.
- Async `rst` low during LOAD and during RUN with full FIFO → all outputs at reset values within the same cycle; `out_valid`=0 after release.
- Random `in_valid`/`out_ready` (50%) for 2000 ops → no drop or duplication, tags in order, `busy`=0 at the end.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calc_sched sequencer and its result FIFO.
package calc_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} calc_state_t;

  localparam int D_W         = 12;
  localparam int Y_W         = 13;
  localparam int LOAD_CYCLES = 12;
  localparam int LAT_DEFAULT = 6;

endpackage

// File: rtl/calc_res_fifo.sv
// Result FIFO with a registered head; a written entry becomes visible one cycle later.
module calc_res_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    after_pop;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    pop_ok    = pop && head_valid;
    push_ok   = push && ((count != CW'(DEPTH)) || pop_ok);
    rd_next   = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    after_pop = count - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // The head reloads only from entries that existed before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_next;
      count      <= after_pop + CW'(push_ok);
      head_valid <= (after_pop != '0);
      if (after_pop != '0) head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/calc_sched.sv
// Sequencer for the a*b*cos(c)/(a+d) datapath: serial d load, credited issue, result buffering.
module calc_sched
  import calc_pkg::*;
#(
  parameter int LAT        = LAT_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [D_W-1:0]   cfg_d,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D_W-1:0]   in_a,
  input  logic [D_W-1:0]   in_b,
  input  logic [D_W-1:0]   in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Y_W-1:0]   out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             dp_rst,
  output logic             dp_e,
  output logic [D_W-1:0]   dp_a,
  output logic [D_W-1:0]   dp_b,
  output logic [D_W-1:0]   dp_c,
  input  logic [Y_W-1:0]   dp_y,
  output logic             loaded,
  output logic             busy
);

  localparam int IW = $clog2(LAT + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = ((IW > CW) ? IW : CW) + 1;
  localparam int BW = $clog2(LOAD_CYCLES);

  calc_state_t            state;
  logic [D_W-1:0]         d_sr;
  logic [BW-1:0]          bit_cnt;
  logic [IW-1:0]          inflight;
  logic [CW-1:0]          fifo_count;
  logic [LAT-1:0]         pipe_v;
  logic [TAG_W-1:0]       pipe_tag [LAT];
  logic [SW-1:0]          credit_used;
  logic                   issue;
  logic                   fifo_pop;
  logic                   head_valid;
  logic [Y_W+TAG_W-1:0]   head;

  // Pops are not credited, so a full FIFO blocks issue even while draining.
  always_comb begin
    credit_used = SW'(inflight) + SW'(fifo_count);
    in_ready    = (state == RUN) && !cfg_valid && (credit_used < SW'(FIFO_DEPTH));
    issue       = in_valid && in_ready;
    cfg_ready   = (state == IDLE);
    fifo_pop    = head_valid && out_ready;
    busy        = (state != IDLE) || (inflight != '0) || (fifo_count != '0);
  end

  assign out_valid = head_valid;
  assign out_y     = head[Y_W+TAG_W-1 -: Y_W];
  assign out_tag   = head[TAG_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dp_rst  <= 1'b1;
      dp_e    <= 1'b0;
      loaded  <= 1'b0;
      d_sr    <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (cfg_valid) begin
          state   <= LOAD;
          dp_rst  <= 1'b0;
          dp_e    <= cfg_d[0];
          d_sr    <= cfg_d >> 1;
          bit_cnt <= '0;
        end
        LOAD: if (bit_cnt == BW'(LOAD_CYCLES - 1)) begin
          state  <= RUN;
          dp_e   <= 1'b0;
          loaded <= 1'b1;
        end else begin
          dp_e    <= d_sr[0];
          d_sr    <= d_sr >> 1;
          bit_cnt <= bit_cnt + BW'(1);
        end
        RUN: if (cfg_valid) begin
          state  <= DRAIN;
          loaded <= 1'b0;
        end
        DRAIN: if (inflight == '0) begin
          state  <= IDLE;
          dp_rst <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The tag pipe shifts every cycle so its tail lines up with dp_y.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_a     <= '0;
      dp_b     <= '0;
      dp_c     <= '0;
      pipe_v   <= '0;
      inflight <= '0;
      for (int k = 0; k < LAT; k++) pipe_tag[k] <= '0;
    end else begin
      if (issue) begin
        dp_a <= in_a;
        dp_b <= in_b;
        dp_c <= in_c;
      end
      pipe_v      <= {pipe_v[LAT-2:0], issue};
      pipe_tag[0] <= in_tag;
      for (int k = 1; k < LAT; k++) pipe_tag[k] <= pipe_tag[k-1];
      inflight <= inflight + IW'(issue) - IW'(pipe_v[LAT-1]);
    end
  end

  calc_res_fifo #(
    .WIDTH (Y_W + TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (pipe_v[LAT-1]),
    .wdata      ({dp_y, pipe_tag[LAT-1]}),
    .pop        (fifo_pop),
    .head_valid (head_valid),
    .head       (head),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_calc_sched.sv
// Directed and randomised bench for calc_sched with a behavioural datapath stub and scoreboard.
module tb_calc_sched;
  import calc_pkg::*;

  localparam int LAT        = 6;
  localparam int FIFO_DEPTH = 8;
  localparam int TAG_W      = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [11:0]      cfg_d = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [11:0]      in_a = '0;
  logic [11:0]      in_b = '0;
  logic [11:0]      in_c = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [12:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             dp_rst;
  logic             dp_e;
  logic [11:0]      dp_a;
  logic [11:0]      dp_b;
  logic [11:0]      dp_c;
  logic [12:0]      dp_y;
  logic             loaded;
  logic             busy;

  calc_sched #(
    .LAT        (LAT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TAG_W      (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_d     (cfg_d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .dp_rst    (dp_rst),
    .dp_e      (dp_e),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_c      (dp_c),
    .dp_y      (dp_y),
    .loaded    (loaded),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ops_in = 0;
  int ops_out = 0;
  logic [11:0] cur_d = '0;

  int probe_armed = 0;
  int probe_issued = 0;
  int probe_done = 0;
  int probe_issue_cyc = 0;
  int probe_out_cyc = 0;

  typedef struct packed {
    logic [12:0]      y;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [12:0] dp_func(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] c, input logic [11:0] d);
    logic [11:0] s;
    s = b + c;
    return {a[11] ^ b[11] ^ c[0], a ^ s ^ d};
  endfunction

  // Datapath stand-in: 12 serial d bits after reset, dp_y valid LAT-1 edges after operands settle.
  logic [11:0] stub_d;
  int          stub_cnt;
  logic [12:0] stub_s [LAT-1];

  always @(posedge clk) begin
    if (dp_rst) begin
      stub_cnt <= 0;
      stub_d   <= '0;
      for (int k = 0; k < LAT - 1; k++) stub_s[k] <= '0;
    end else begin
      if (stub_cnt < LOAD_CYCLES) begin
        stub_d   <= {dp_e, stub_d[11:1]};
        stub_cnt <= stub_cnt + 1;
      end
      stub_s[0] <= dp_func(dp_a, dp_b, dp_c, stub_d);
      for (int k = 1; k < LAT - 1; k++) stub_s[k] <= stub_s[k-1];
    end
  end

  assign dp_y = stub_s[LAT-2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: records accepted operands and checks each delivered result in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (in_valid && in_ready) begin
        e.y   = dp_func(in_a, in_b, in_c, cur_d);
        e.tag = in_tag;
        exp_q.push_back(e);
        ops_in++;
        if (probe_armed != 0 && probe_issued == 0) begin
          probe_issue_cyc = cyc + 1;
          probe_issued    = 1;
        end
      end
      if (out_valid && probe_issued != 0 && probe_done == 0) begin
        probe_out_cyc = cyc;
        probe_done    = 1;
      end
      if (out_valid && out_ready) begin
        ops_out++;
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_y", 32'(out_y), 32'(e.y));
          checkOutput("out_tag", 32'(out_tag), 32'(e.tag));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b,
                               input logic [11:0] c, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
    in_tag = tag;
    #1;
    for (int i = 0; i < 300 && !in_ready; i++) tick();
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_coeff(input logic [11:0] d);
    cfg_valid = 1'b1;
    cfg_d = d;
    #1;
    for (int i = 0; i < 60 && !cfg_ready; i++) tick();
    checkOutput("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    checkOutput("idle_dp_rst", 32'(dp_rst), 32'd1);
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < LOAD_CYCLES; i++) tick();
    checkOutput("loaded", 32'(loaded), 32'd1);
    cur_d = d;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick();
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string where);
    checkOutput({where, "_dp_rst"}, 32'(dp_rst), 32'd1);
    checkOutput({where, "_dp_e"}, 32'(dp_e), 32'd0);
    checkOutput({where, "_dp_a"}, 32'(dp_a), 32'd0);
    checkOutput({where, "_dp_b"}, 32'(dp_b), 32'd0);
    checkOutput({where, "_dp_c"}, 32'(dp_c), 32'd0);
    checkOutput({where, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({where, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    checkOutput({where, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({where, "_out_y"}, 32'(out_y), 32'd0);
    checkOutput({where, "_out_tag"}, 32'(out_tag), 32'd0);
    checkOutput({where, "_loaded"}, 32'(loaded), 32'd0);
    checkOutput({where, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic exp_e [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int base_in;
    int base_out;
    int n;

    #2 rst = 1'b0;
    #10;
    check_reset_values("por");
    @(negedge clk) rst = 1'b1;
    tick();

    $display("[TB] serial load of 12'hA5C");
    cfg_d = 12'hA5C;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < LOAD_CYCLES; i++) begin
      checkOutput($sformatf("dp_e_bit%0d", i), 32'(dp_e), 32'(exp_e[i]));
      checkOutput("dp_rst_in_load", 32'(dp_rst), 32'd0);
      checkOutput("loaded_early", 32'(loaded), 32'd0);
      tick();
    end
    checkOutput("loaded_13th_edge", 32'(loaded), 32'd1);
    checkOutput("in_ready_run", 32'(in_ready), 32'd1);
    cur_d = 12'hA5C;

    $display("[TB] ten back-to-back ops");
    out_ready = 1'b1;
    base_out = ops_out;
    probe_armed = 1;
    for (int i = 0; i < 10; i++)
      applyStimulus(12'(i * 37 + 5), 12'(i * 91 + 3), 12'(i * 13 + 700), 4'(i));
    wait_drain();
    checkOutput("first_out_latency", 32'(probe_done), 32'd1);
    checkOutput("first_out_edges", 32'(probe_out_cyc - probe_issue_cyc), 32'd7);
    checkOutput("ten_delivered", 32'(ops_out - base_out), 32'd10);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    base_in = ops_in;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      n = ops_in - base_in;
      in_a = 12'(n * 111 + 1);
      in_b = 12'(n * 7 + 2000);
      in_c = 12'(n * 300);
      in_tag = 4'(n);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checkOutput("bp_accepted", 32'(ops_in - base_in), 32'd8);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_drain();
    checkOutput("bp_readmit", 32'(in_ready), 32'd1);
    applyStimulus(12'h123, 12'h456, 12'h789, 4'd8);
    applyStimulus(12'hFFF, 12'h001, 12'h800, 4'd9);
    wait_drain();

    $display("[TB] reload with ops in flight");
    out_ready = 1'b0;
    base_in = ops_in;
    applyStimulus(12'h0AA, 12'h055, 12'h3C3, 4'd10);
    applyStimulus(12'h7FF, 12'h800, 12'h111, 4'd11);
    applyStimulus(12'h246, 12'h8AC, 12'hE02, 4'd12);
    cfg_valid = 1'b1;
    cfg_d = 12'h3B7;
    in_valid = 1'b1;
    in_a = 12'h999;
    in_tag = 4'd13;
    #1;
    checkOutput("reload_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reload_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 60 && !cfg_ready; i++) tick();
    checkOutput("reload_results_buffered", 32'(out_valid), 32'd1);
    checkOutput("reload_no_extra_issue", 32'(ops_in - base_in), 32'd3);
    load_coeff(12'h3B7);
    applyStimulus(12'h135, 12'h246, 12'h357, 4'd14);
    applyStimulus(12'hABC, 12'hDEF, 12'h012, 4'd15);
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] async reset with full FIFO");
    out_ready = 1'b0;
    base_in = ops_in;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n = ops_in - base_in;
      in_a = 12'(n + 40);
      in_b = 12'(n * 5);
      in_c = 12'(n * 9);
      in_tag = 4'(n);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("full_accepted", 32'(ops_in - base_in), 32'd8);
    #2 rst = 1'b0;
    #1;
    check_reset_values("run_rst");
    exp_q.delete();
    @(negedge clk) rst = 1'b1;
    tick();
    checkOutput("run_rst_out_valid_after", 32'(out_valid), 32'd0);

    $display("[TB] async reset during load");
    cfg_d = 12'h5A5;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("load_mid_dp_rst", 32'(dp_rst), 32'd0);
    #2 rst = 1'b0;
    #1;
    check_reset_values("load_rst");
    @(negedge clk) rst = 1'b1;
    tick();
    checkOutput("load_rst_out_valid_after", 32'(out_valid), 32'd0);

    $display("[TB] random traffic");
    load_coeff(12'h6E1);
    base_in = ops_in;
    base_out = ops_out;
    for (int i = 0; i < 30000 && (ops_out - base_out) < 2000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ((ops_in - base_in) < 2000 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_a = 12'($urandom);
        in_b = 12'($urandom);
        in_c = 12'($urandom);
        in_tag = 4'(ops_in - base_in);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    checkOutput("rand_ops_in", 32'(ops_in - base_in), 32'd2000);
    checkOutput("rand_ops_out", 32'(ops_out - base_out), 32'd2000);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("final_busy", 32'(busy), 32'd0);
    checkOutput("final_cfg_ready", 32'(cfg_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
